// File: rtl/otter_bp_pkg.sv
// Shared types and address-split helpers for the OTTER branch target buffer.
// Helpers work on a widest-case address so any XLEN up to 64 can use them.
package otter_bp_pkg;

  localparam int BP_MAX_XLEN     = 64;
  localparam int BP_MAX_CTR_BITS = 4;

  // MSB-aligned: the top CTR_BITS bits give 2^(CTR_BITS-1) for any width 1..4
  localparam logic [BP_MAX_CTR_BITS-1:0] CTR_WEAK_TAKEN = 4'b1000;

  typedef logic [BP_MAX_XLEN-1:0] bp_addr_t;

  typedef enum logic [1:0] {
    CTR_INC,
    CTR_DEC,
    CTR_SET_MAX,
    CTR_SET_WEAK
  } ctr_op_e;

  typedef struct packed {
    logic                       valid;
    bp_addr_t                   tag;
    bp_addr_t                   target;
    logic [BP_MAX_CTR_BITS-1:0] ctr;
  } bp_entry_t;

  function automatic bp_addr_t bp_index(input bp_addr_t pc, input int idx_w);
    return (pc >> 2) & ((bp_addr_t'(1) << idx_w) - bp_addr_t'(1));
  endfunction

  function automatic bp_addr_t bp_tag(input bp_addr_t pc, input int idx_w, input int tag_w);
    return (pc >> (idx_w + 2)) & ((bp_addr_t'(1) << tag_w) - bp_addr_t'(1));
  endfunction

endpackage

// File: rtl/otter_branch_predictor_if.sv
// Fetch-side lookup and execute-side update bundle for the branch predictor.
interface otter_branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            FLUSH;
  logic [XLEN-1:0] LOOKUP_PC;
  logic            PRED_HIT;
  logic            PRED_TAKEN;
  logic [XLEN-1:0] PRED_NEXT_PC;
  logic            UPD_VALID;
  logic [XLEN-1:0] UPD_PC;
  logic            UPD_TAKEN;
  logic [XLEN-1:0] UPD_TARGET;
  logic            UPD_UNCOND;

  modport master (
    output FLUSH, LOOKUP_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_UNCOND,
    input  PRED_HIT, PRED_TAKEN, PRED_NEXT_PC
  );

  modport slave (
    input  FLUSH, LOOKUP_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_UNCOND,
    output PRED_HIT, PRED_TAKEN, PRED_NEXT_PC
  );
endinterface

// File: rtl/otter_sat_counter.sv
// Combinational next-value for a saturating direction counter.
module otter_sat_counter
  import otter_bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  ctr_op_e             op,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_WEAK_TAKEN[BP_MAX_CTR_BITS-1 -: CTR_BITS];

  function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] v);
    return (v == CTR_MAX) ? v : v + CTR_BITS'(1);
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] v);
    return (v == '0) ? v : v - CTR_BITS'(1);
  endfunction

  always_comb begin
    ctr_next = ctr;
    unique case (op)
      CTR_INC:      ctr_next = sat_inc(ctr);
      CTR_DEC:      ctr_next = sat_dec(ctr);
      CTR_SET_MAX:  ctr_next = CTR_MAX;
      CTR_SET_WEAK: ctr_next = CTR_WEAK;
    endcase
  end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with saturating-counter direction prediction.
// Lookup is zero-latency from registered state; updates land at the next edge.
module otter_branch_predictor
  import otter_bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_W    = 8,
  parameter int CTR_BITS = 2
) (
  input logic                     CLK,
  input logic                     RESET,
  otter_branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  bp_addr_t         lk_pc, up_pc;
  logic [IDX_W-1:0] lk_idx, up_idx;
  bp_entry_t        lk_ent, up_ent;
  logic             lk_hit, lk_taken, up_hit;
  logic             upd_go, upd_we, upd_alloc, upd_tgt_we;
  ctr_op_e          ctr_op;
  logic [CTR_BITS-1:0] ctr_next;
  logic             unused_bits;

  assign lk_pc  = bp_addr_t'(bp.LOOKUP_PC);
  assign up_pc  = bp_addr_t'(bp.UPD_PC);
  assign lk_idx = IDX_W'(bp_index(lk_pc, IDX_W));
  assign up_idx = IDX_W'(bp_index(up_pc, IDX_W));

  always_comb begin
    lk_ent = '{valid:  valid_q[lk_idx],
               tag:    bp_addr_t'(tag_q[lk_idx]),
               target: bp_addr_t'(target_q[lk_idx]),
               ctr:    BP_MAX_CTR_BITS'(ctr_q[lk_idx])};
    up_ent = '{valid:  valid_q[up_idx],
               tag:    bp_addr_t'(tag_q[up_idx]),
               target: bp_addr_t'(target_q[up_idx]),
               ctr:    BP_MAX_CTR_BITS'(ctr_q[up_idx])};
  end

  // Wide decoded views carry zero-extension bits that nothing consumes
  assign unused_bits = ^{lk_ent, up_ent};

  assign lk_hit   = lk_ent.valid && (lk_ent.tag == bp_tag(lk_pc, IDX_W, TAG_W));
  assign lk_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];

  assign bp.PRED_HIT     = lk_hit;
  assign bp.PRED_TAKEN   = lk_taken;
  assign bp.PRED_NEXT_PC = lk_taken ? target_q[lk_idx] : bp.LOOKUP_PC + XLEN'(4);

  // An update arriving with RESET or FLUSH is dropped outright
  assign up_hit     = up_ent.valid && (up_ent.tag == bp_tag(up_pc, IDX_W, TAG_W));
  assign upd_go     = bp.UPD_VALID && !RESET && !bp.FLUSH;
  assign upd_alloc  = upd_go && !up_hit && bp.UPD_TAKEN;
  assign upd_we     = upd_alloc || (upd_go && up_hit);
  assign upd_tgt_we = upd_we && (bp.UPD_TAKEN || bp.UPD_UNCOND);

  always_comb begin
    if (bp.UPD_UNCOND)    ctr_op = CTR_SET_MAX;
    else if (!up_hit)     ctr_op = CTR_SET_WEAK;
    else if (bp.UPD_TAKEN) ctr_op = CTR_INC;
    else                  ctr_op = CTR_DEC;
  end

  otter_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
    .ctr      (ctr_q[up_idx]),
    .op       (ctr_op),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET || bp.FLUSH) valid_q <= '0;
    else if (upd_alloc)    valid_q[up_idx] <= 1'b1;
  end

  // Payload is meaningless while invalid, so it carries no reset
  always_ff @(posedge CLK) begin
    if (upd_we) begin
      tag_q[up_idx] <= TAG_W'(bp_tag(up_pc, IDX_W, TAG_W));
      ctr_q[up_idx] <= ctr_next;
    end
    if (upd_tgt_we) target_q[up_idx] <= bp.UPD_TARGET;
  end

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Vector-table bench for otter_branch_predictor with an expectation queue.
module tb_otter_branch_predictor;

  logic CLK = 1'b0;
  logic RESET;

  otter_branch_predictor_if #(.XLEN(32)) bp_if ();

  otter_branch_predictor #(
    .XLEN(32), .ENTRIES(16), .TAG_W(8), .CTR_BITS(2)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bp    (bp_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst, flush, uv;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic        unc;
    logic [31:0] lpc;
    logic        hit, tk;
    logic [31:0] nxt;
  } vec_t;

  typedef struct {
    string       name;
    logic        hit, tk;
    logic [31:0] nxt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input string name, input logic rst, input logic flush,
                              input logic uv, input logic [31:0] upc, input logic utk,
                              input logic [31:0] utgt, input logic unc, input logic [31:0] lpc,
                              input logic hit, input logic tk, input logic [31:0] nxt);
    vec_t v;
    v.name = name; v.rst = rst; v.flush = flush; v.uv = uv; v.upc = upc; v.utk = utk;
    v.utgt = utgt; v.unc = unc; v.lpc = lpc; v.hit = hit; v.tk = tk; v.nxt = nxt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge CLK);
    RESET            = v.rst;
    bp_if.FLUSH      = v.flush;
    bp_if.UPD_VALID  = v.uv;
    bp_if.UPD_PC     = v.upc;
    bp_if.UPD_TAKEN  = v.utk;
    bp_if.UPD_TARGET = v.utgt;
    bp_if.UPD_UNCOND = v.unc;
    bp_if.LOOKUP_PC  = v.lpc;
    e.name = v.name; e.hit = v.hit; e.tk = v.tk; e.nxt = v.nxt;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({e.name, ".hit"},  32'(bp_if.PRED_HIT),   32'(e.hit));
    check({e.name, ".taken"}, 32'(bp_if.PRED_TAKEN), 32'(e.tk));
    check({e.name, ".next"}, bp_if.PRED_NEXT_PC,    e.nxt);
  endtask

  initial begin
    RESET = 1'b1;
    bp_if.FLUSH = 1'b0; bp_if.UPD_VALID = 1'b0; bp_if.UPD_PC = '0; bp_if.UPD_TAKEN = 1'b0;
    bp_if.UPD_TARGET = '0; bp_if.UPD_UNCOND = 1'b0; bp_if.LOOKUP_PC = '0;
    repeat (2) @(posedge CLK);

    //               name           rst flu uv  upc         tk  tgt         unc lpc          hit tk  next
    vecs.push_back(mk("post_reset",  0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h100,      0, 0, 32'h104));
    vecs.push_back(mk("alloc_same",  0, 0, 1, 32'h100,     1, 32'h200,     0, 32'h100,      0, 0, 32'h104));
    vecs.push_back(mk("weak_taken",  0, 0, 1, 32'h100,     0, 32'h0,       0, 32'h100,      1, 1, 32'h200));
    vecs.push_back(mk("ctr1",        0, 0, 1, 32'h100,     0, 32'h0,       0, 32'h100,      1, 0, 32'h104));
    vecs.push_back(mk("ctr0",        0, 0, 1, 32'h100,     0, 32'h0,       0, 32'h100,      1, 0, 32'h104));
    vecs.push_back(mk("ctr0_sat",    0, 0, 1, 32'h100,     1, 32'h200,     0, 32'h100,      1, 0, 32'h104));
    vecs.push_back(mk("inc_ctr1",    0, 0, 1, 32'h100,     1, 32'h200,     0, 32'h100,      1, 0, 32'h104));
    vecs.push_back(mk("inc_ctr2",    0, 0, 1, 32'h100,     1, 32'h200,     0, 32'h100,      1, 1, 32'h200));
    vecs.push_back(mk("inc_ctr3",    0, 0, 1, 32'h100,     1, 32'h200,     0, 32'h100,      1, 1, 32'h200));
    vecs.push_back(mk("ctr3_sat",    0, 0, 1, 32'h100,     0, 32'h0,       0, 32'h100,      1, 1, 32'h200));
    vecs.push_back(mk("dec_ctr2",    0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h100,      1, 1, 32'h200));
    vecs.push_back(mk("alias_miss",  0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h140,      0, 0, 32'h144));
    vecs.push_back(mk("uncond_upd",  0, 0, 1, 32'h140,     1, 32'h80,      1, 32'h140,      0, 0, 32'h144));
    vecs.push_back(mk("uncond_hit",  0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h140,      1, 1, 32'h80));
    vecs.push_back(mk("evicted",     0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h100,      0, 0, 32'h104));
    vecs.push_back(mk("nt_miss",     0, 0, 1, 32'h1C0,     0, 32'h999,     0, 32'h1C0,      0, 0, 32'h1C4));
    vecs.push_back(mk("kept_entry",  0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h140,      1, 1, 32'h80));
    vecs.push_back(mk("max_dec_a",   0, 0, 1, 32'h140,     0, 32'h0,       0, 32'h140,      1, 1, 32'h80));
    vecs.push_back(mk("max_dec_b",   0, 0, 1, 32'h140,     0, 32'h0,       0, 32'h140,      1, 1, 32'h80));
    vecs.push_back(mk("max_dec_c",   0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h140,      1, 0, 32'h144));
    vecs.push_back(mk("no_bypass",   0, 0, 1, 32'h104,     1, 32'h300,     0, 32'h104,      0, 0, 32'h108));
    vecs.push_back(mk("after_upd",   0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h104,      1, 1, 32'h300));
    vecs.push_back(mk("flush_cyc",   0, 1, 1, 32'h108,     1, 32'h400,     0, 32'h104,      1, 1, 32'h300));
    vecs.push_back(mk("flushed_104", 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h104,      0, 0, 32'h108));
    vecs.push_back(mk("flushed_108", 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h108,      0, 0, 32'h10C));
    vecs.push_back(mk("flushed_140", 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h140,      0, 0, 32'h144));
    vecs.push_back(mk("refill",      0, 0, 1, 32'h104,     1, 32'h300,     0, 32'h104,      0, 0, 32'h108));
    vecs.push_back(mk("refilled",    0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h104,      1, 1, 32'h300));
    vecs.push_back(mk("reset_cyc",   1, 0, 1, 32'h108,     1, 32'h400,     0, 32'h104,      1, 1, 32'h300));
    vecs.push_back(mk("reset_104",   0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h104,      0, 0, 32'h108));
    vecs.push_back(mk("reset_108",   0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h108,      0, 0, 32'h10C));
    vecs.push_back(mk("wrap_miss",   0, 0, 0, 32'h0,       0, 32'h0,       0, 32'hFFFFFFFC, 0, 0, 32'h0));

    foreach (vecs[i]) apply(vecs[i]);

    // Top-of-memory entry, hit-side not-taken keeps the target, then a high-bit alias
    apply(mk("top_alloc",   0, 0, 1, 32'hFFFFFFFC, 1, 32'h10, 1, 32'hFFFFFFFC, 0, 0, 32'h0));
    apply(mk("top_hit_nt",  0, 0, 1, 32'hFFFFFFFC, 0, 32'h77, 0, 32'hFFFFFFFC, 1, 1, 32'h10));
    apply(mk("top_kept",    0, 0, 0, 32'h0,        0, 32'h0,  0, 32'hFFFFFFFC, 1, 1, 32'h10));
    apply(mk("alias_share", 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0000FFFC, 1, 1, 32'h10));

    // Flush with an update that would hit must still leave the entry invalid
    apply(mk("flush_hit",   0, 1, 1, 32'hFFFFFFFC, 1, 32'h20, 1, 32'hFFFFFFFC, 1, 1, 32'h10));
    apply(mk("flush_done",  0, 0, 0, 32'h0,        0, 32'h0,  0, 32'hFFFFFFFC, 0, 0, 32'h0));

    @(negedge CLK);
    bp_if.UPD_VALID = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
